// File: rtl/eth_tx_arbiter.sv
// Two-port Ethernet transmit arbiter.
// Round-robin selection at frame granularity between two byte-stream
// requesters, frame truncation at MAX_LEN beats, and a fixed inter-frame
// gap on the master port. Per-port completed-frame counters.
module eth_tx_arbiter #(
    parameter int IFG_CYCLES = 12,
    parameter int MAX_LEN    = 1518
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic [7:0]  s0_data,
    input  logic        s0_valid,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic [7:0]  s1_data,
    input  logic        s1_valid,
    input  logic        s1_last,
    output logic        s1_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [1:0]  grant,
    output logic        trunc_err,
    output logic [15:0] frm_cnt0,
    output logic [15:0] frm_cnt1
);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DROP, ST_IFG} state_t;

    localparam logic [13:0] LAST_BEAT = 14'(MAX_LEN - 1);
    localparam logic [7:0]  IFG_LOAD  = 8'(IFG_CYCLES);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;       // preferred port for the next tie
    logic [1:0]  grant_q, grant_d;
    logic [13:0] beat_q, beat_d;
    logic [7:0]  ifg_q, ifg_d;
    logic        trunc_d;
    logic        cnt0_inc, cnt1_inc;
    logic        pick;

    // Granted-port view: grant_q[1] selects port 1, otherwise port 0.
    logic        g_sel;
    logic [7:0]  g_data;
    logic        g_valid, g_last, force_trunc;

    assign g_sel       = grant_q[1];
    assign g_data      = g_sel ? s1_data  : s0_data;
    assign g_valid     = g_sel ? s1_valid : s0_valid;
    assign g_last      = g_sel ? s1_last  : s0_last;
    assign force_trunc = (beat_q == LAST_BEAT) && !g_last;
    assign grant       = grant_q;

    // Next-state and output decode for the arbitration FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        ifg_d    = ifg_q;
        trunc_d  = 1'b0;
        cnt0_inc = 1'b0;
        cnt1_inc = 1'b0;
        pick     = 1'b0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    // A lone requester wins outright; a tie goes to the pointer.
                    pick    = (s0_valid && s1_valid) ? ptr_q : s1_valid;
                    grant_d = pick ? 2'b10 : 2'b01;
                    beat_d  = 14'd0;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                m_data  = g_data;
                m_valid = g_valid;
                m_last  = g_last || force_trunc;
                if (g_sel) s1_ready = m_ready;
                else       s0_ready = m_ready;
                if (g_valid && m_ready) begin
                    beat_d = beat_q + 14'd1;
                    if (g_last || force_trunc) begin
                        cnt0_inc = !g_sel;
                        cnt1_inc = g_sel;
                        ptr_d    = !g_sel;
                        if (g_last) begin
                            grant_d = 2'b00;
                            ifg_d   = IFG_LOAD;
                            state_d = ST_IFG;
                        end else begin
                            trunc_d = 1'b1;
                            state_d = ST_DROP;
                        end
                    end
                end
            end

            ST_DROP: begin
                // Swallow the tail of a truncated frame without presenting it.
                if (g_sel) s1_ready = 1'b1;
                else       s0_ready = 1'b1;
                if (g_valid && g_last) begin
                    grant_d = 2'b00;
                    ifg_d   = IFG_LOAD;
                    state_d = ST_IFG;
                end
            end

            ST_IFG: begin
                if (ifg_q <= 8'd1) state_d = ST_IDLE;
                else               ifg_d   = ifg_q - 8'd1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and the truncation pulse register.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            grant_q   <= 2'b00;
            beat_q    <= 14'd0;
            ifg_q     <= 8'd0;
            trunc_err <= 1'b0;
            frm_cnt0  <= 16'd0;
            frm_cnt1  <= 16'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            ifg_q     <= ifg_d;
            trunc_err <= trunc_d;
            if (cnt0_inc) frm_cnt0 <= frm_cnt0 + 16'd1;
            if (cnt1_inc) frm_cnt1 <= frm_cnt1 + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Testbench for eth_tx_arbiter: per-port expected-byte queues filled as
// requester beats are driven, drained by a master-side monitor.
module tb_eth_tx_arbiter;

    localparam int IFG     = 12;
    localparam int MAXL    = 1518;
    localparam int GAP_EXP = IFG + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s0_data, s1_data, m_data;
    logic        s0_valid, s0_last, s0_ready;
    logic        s1_valid, s1_last, s1_ready;
    logic        m_valid, m_last, m_ready;
    logic [1:0]  grant;
    logic        trunc_err;
    logic [15:0] frm_cnt0, frm_cnt1;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    logic [1:0] grant_log[$];
    int  beats0, beats1, trunc_cnt, last_gap, gap;
    bit  after_last;
    bit  rand_ready_en;

    always #5 clk = ~clk;

    eth_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL)) dut (
        .i_sys_clk  (clk),
        .i_sys_rst_n(rst_n),
        .s0_data    (s0_data),
        .s0_valid   (s0_valid),
        .s0_last    (s0_last),
        .s0_ready   (s0_ready),
        .s1_data    (s1_data),
        .s1_valid   (s1_valid),
        .s1_last    (s1_last),
        .s1_ready   (s1_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .grant      (grant),
        .trunc_err  (trunc_err),
        .frm_cnt0   (frm_cnt0),
        .frm_cnt1   (frm_cnt1)
    );

    task automatic drive(input int port, input logic v, input logic [7:0] d, input logic l);
        if (port == 0) begin s0_valid = v; s0_data = d; s0_last = l; end
        else           begin s1_valid = v; s1_data = d; s1_last = l; end
    endtask

    // Send the first nsend beats of a len-beat frame; expected master beats
    // are queued as they are driven (beats past MAXL are never expected).
    task automatic send_frame(input int port, input int len, input int base, input int nsend);
        for (int i = 0; i < nsend; i++) begin
            logic [7:0] b;
            logic lst, exp_last, acc;
            int waited;
            b   = 8'(base + i * 7);
            lst = (i == len - 1);
            drive(port, 1'b1, b, lst);
            if (i < MAXL) begin
                exp_last = (i == len - 1) || (i == MAXL - 1);
                if (port == 0) exp_q0.push_back({exp_last, b});
                else           exp_q1.push_back({exp_last, b});
            end
            acc = 1'b0;
            waited = 0;
            while (!acc) begin
                @(negedge clk);
                acc = (port == 0) ? s0_ready : s1_ready;
                waited++;
                @(posedge clk); #1;
                if (!acc && waited > 5000) begin
                    tests++; fails++;
                    $display("FAIL src%0d_timeout beat %0d: no ready after %0d cycles, required accept", port, i, waited);
                    drive(port, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
        end
        drive(port, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                after_last = 1'b0;
                gap = 0;
            end else begin
                if (m_valid && after_last) begin
                    tests++;
                    last_gap = gap;
                    if (gap < GAP_EXP) begin
                        fails++;
                        $display("FAIL ifg_gap got %0d idle cycles, required >= %0d", gap, GAP_EXP);
                    end
                    after_last = 1'b0;
                end else if (!m_valid && after_last) begin
                    gap++;
                end
                if (m_valid && m_ready) begin
                    tests++;
                    if (grant == 2'b01 && exp_q0.size() > 0) begin
                        beats0++;
                        e = exp_q0.pop_front();
                        if ({m_last, m_data} !== e) begin
                            fails++;
                            $display("FAIL beat_p0 got last=%0b data=%02h, required last=%0b data=%02h", m_last, m_data, e[8], e[7:0]);
                        end
                    end else if (grant == 2'b10 && exp_q1.size() > 0) begin
                        beats1++;
                        e = exp_q1.pop_front();
                        if ({m_last, m_data} !== e) begin
                            fails++;
                            $display("FAIL beat_p1 got last=%0b data=%02h, required last=%0b data=%02h", m_last, m_data, e[8], e[7:0]);
                        end
                    end else begin
                        fails++;
                        $display("FAIL unexpected_beat got grant=%02b data=%02h, required no master beat", grant, m_data);
                    end
                    if (m_last) begin
                        after_last = 1'b1;
                        gap = 0;
                        grant_log.push_back(grant);
                    end
                end
                if (trunc_err) trunc_cnt++;
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk); #1;
            if (rand_ready_en) m_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic clear_scoreboard();
        exp_q0.delete(); exp_q1.delete(); grant_log.delete();
        beats0 = 0; beats1 = 0; trunc_cnt = 0; last_gap = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        rand_ready_en = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        clear_scoreboard();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (grant !== 2'b00)   begin fails++; $display("FAIL rst_grant got %02b, required 00", grant); end
        tests++; if (m_valid !== 1'b0)  begin fails++; $display("FAIL rst_m_valid got %0b, required 0", m_valid); end
        tests++; if (m_last !== 1'b0)   begin fails++; $display("FAIL rst_m_last got %0b, required 0", m_last); end
        tests++; if ({s0_ready, s1_ready} !== 2'b00) begin fails++; $display("FAIL rst_ready got %02b, required 00", {s0_ready, s1_ready}); end
        tests++; if (trunc_err !== 1'b0) begin fails++; $display("FAIL rst_trunc got %0b, required 0", trunc_err); end
        tests++; if (frm_cnt0 !== 16'd0) begin fails++; $display("FAIL rst_cnt0 got %0d, required 0", frm_cnt0); end
        tests++; if (frm_cnt1 !== 16'd0) begin fails++; $display("FAIL rst_cnt1 got %0d, required 0", frm_cnt1); end
    endtask

    task automatic test_single_frame();
        do_reset();
        send_frame(0, 64, 8'h10, 64);
        tests++; if (frm_cnt0 !== 16'd1) begin fails++; $display("FAIL single_cnt0 got %0d, required 1", frm_cnt0); end
        tests++; if (grant !== 2'b00)    begin fails++; $display("FAIL single_grant_ifg got %02b, required 00", grant); end
        send_frame(0, 4, 8'h80, 4);
        repeat (2) @(posedge clk);
        tests++; if (grant_log.size() != 2 || grant_log[0] !== 2'b01) begin fails++; $display("FAIL single_grant got log size %0d, required 2 with first grant 01", grant_log.size()); end
        tests++; if (beats0 != 68) begin fails++; $display("FAIL single_beats got %0d, required 68", beats0); end
        tests++; if (last_gap != GAP_EXP) begin fails++; $display("FAIL single_gap got %0d, required %0d", last_gap, GAP_EXP); end
        tests++; if (exp_q0.size() != 0) begin fails++; $display("FAIL single_leftover got %0d pending, required 0", exp_q0.size()); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        fork
            begin send_frame(0, 64, 8'h20, 64); send_frame(0, 64, 8'h40, 64); end
            begin send_frame(1, 64, 8'h60, 64); send_frame(1, 64, 8'h90, 64); end
        join
        repeat (2) @(posedge clk);
        tests++;
        if (grant_log.size() != 4) begin
            fails++; $display("FAIL rr_frames got %0d, required 4", grant_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (grant_log[k] !== exp_g[k]) begin fails++; $display("FAIL rr_grant%0d got %02b, required %02b", k, grant_log[k], exp_g[k]); end
            end
        end
        tests++; if (frm_cnt0 !== 16'd2) begin fails++; $display("FAIL rr_cnt0 got %0d, required 2", frm_cnt0); end
        tests++; if (frm_cnt1 !== 16'd2) begin fails++; $display("FAIL rr_cnt1 got %0d, required 2", frm_cnt1); end
    endtask

    task automatic test_truncation();
        do_reset();
        send_frame(1, 2000, 8'h33, 2000);
        repeat (2) @(posedge clk);
        tests++; if (beats1 != MAXL) begin fails++; $display("FAIL trunc_beats got %0d, required %0d", beats1, MAXL); end
        tests++; if (trunc_cnt != 1) begin fails++; $display("FAIL trunc_pulses got %0d, required 1", trunc_cnt); end
        tests++; if (frm_cnt1 !== 16'd1) begin fails++; $display("FAIL trunc_cnt1 got %0d, required 1", frm_cnt1); end
        tests++; if (exp_q1.size() != 0) begin fails++; $display("FAIL trunc_leftover got %0d pending, required 0", exp_q1.size()); end
    endtask

    task automatic test_exact_max();
        do_reset();
        send_frame(0, MAXL, 8'h05, MAXL);
        send_frame(0, 3, 8'hA0, 3);
        repeat (2) @(posedge clk);
        tests++; if (trunc_cnt != 0) begin fails++; $display("FAIL exact_trunc got %0d pulses, required 0", trunc_cnt); end
        tests++; if (beats0 != MAXL + 3) begin fails++; $display("FAIL exact_beats got %0d, required %0d", beats0, MAXL + 3); end
        tests++; if (frm_cnt0 !== 16'd2) begin fails++; $display("FAIL exact_cnt0 got %0d, required 2", frm_cnt0); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rand_ready_en = 1'b1;
        send_frame(0, 100, 8'h55, 100);
        rand_ready_en = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        tests++; if (beats0 != 100) begin fails++; $display("FAIL bp_beats got %0d, required 100", beats0); end
        tests++; if (exp_q0.size() != 0) begin fails++; $display("FAIL bp_leftover got %0d pending, required 0", exp_q0.size()); end
        tests++; if (frm_cnt0 !== 16'd1) begin fails++; $display("FAIL bp_cnt0 got %0d, required 1", frm_cnt0); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_frame(0, 8, 8'h11, 8);
        tests++; if (frm_cnt0 !== 16'd1) begin fails++; $display("FAIL mid_precnt got %0d, required 1", frm_cnt0); end
        send_frame(0, 64, 8'h22, 30);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (grant !== 2'b00)   begin fails++; $display("FAIL mid_grant got %02b, required 00", grant); end
        tests++; if (m_valid !== 1'b0)  begin fails++; $display("FAIL mid_m_valid got %0b, required 0", m_valid); end
        tests++; if (s0_ready !== 1'b0) begin fails++; $display("FAIL mid_s0_ready got %0b, required 0", s0_ready); end
        tests++; if (frm_cnt0 !== 16'd0) begin fails++; $display("FAIL mid_cnt0 got %0d, required 0", frm_cnt0); end
        @(posedge clk);
        clear_scoreboard();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fork
            send_frame(0, 4, 8'h44, 4);
            send_frame(1, 4, 8'h66, 4);
        join
        repeat (2) @(posedge clk);
        tests++;
        if (grant_log.size() != 2 || grant_log[0] !== 2'b01 || grant_log[1] !== 2'b10) begin
            fails++; $display("FAIL mid_restart_order got %0d frames first=%02b, required 2 frames 01 then 10", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 2'bxx);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        @(negedge clk);
        force dut.frm_cnt0 = 16'hFFFF;
        @(negedge clk);
        release dut.frm_cnt0;
        @(posedge clk); #1;
        send_frame(0, 4, 8'h77, 4);
        repeat (2) @(posedge clk);
        tests++; if (frm_cnt0 !== 16'h0000) begin fails++; $display("FAIL wrap_cnt0 got %04h, required 0000", frm_cnt0); end
        tests++; if (frm_cnt1 !== 16'h0000) begin fails++; $display("FAIL wrap_cnt1 got %04h, required 0000", frm_cnt1); end
    endtask

    initial begin
        rst_n = 1'b0;
        m_ready = 1'b1;
        rand_ready_en = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        clear_scoreboard();
        after_last = 1'b0;
        gap = 0;
        fork
            monitor();
            ready_driver();
            begin
                #800000;
                $display("FAIL watchdog: time limit reached, required completion");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_single_frame();
        test_round_robin();
        test_truncation();
        test_exact_max();
        test_backpressure();
        test_reset_midframe();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
